// File: rtl/button_event_if.sv
// Press-event handshake between button_event_unit (master) and its consumer (slave).
// Carries the valid/ready pair and the index of the presented button.
interface button_event_if #(
  parameter int NBTN = 7
);
  localparam int IW = $clog2(NBTN);

  logic          press_valid;
  logic [IW-1:0] press_idx;
  logic          press_ready;

  modport master (output press_valid, output press_idx, input press_ready);
  modport slave  (input press_valid, input press_idx, output press_ready);
endinterface

// File: rtl/button_event_unit.sv
// Button front end: synchronise, debounce on the prescaler tick, queue rising presses
// and hand them out one at a time by index. Define BTN_REPEAT_EN to build auto-repeat.
module button_event_unit #(
  parameter int NBTN         = 7,
  parameter int DEB_TICKS    = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic            any_held,
  output logic            press_lost,
  button_event_if.master  evt
);
  localparam int IW = $clog2(NBTN);

  if (NBTN < 2 || NBTN > 8 || DEB_TICKS < 1 || DEB_TICKS > 15 ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
      REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_param_check
    $error("button_event_unit: parameter out of range");
  end

  function automatic logic [IW-1:0] lowest(input logic [NBTN-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int unsigned i = NBTN; i > 0; i--) begin
      if (v[i-1]) r = IW'(i - 1);
    end
    return r;
  endfunction

  logic [NBTN-1:0] sync1, sync2;
  logic [3:0]      cnt [NBTN];
  logic [NBTN-1:0] lvl_next, rise, rep_set, set_req;
  logic [NBTN-1:0] pend, pend_clr, pend_next, drop;
  logic            slot_free, load;
  logic [IW-1:0]   load_idx;

  assign any_held = |btn_level;

  always_comb begin
    lvl_next = btn_level;
    for (int unsigned i = 0; i < NBTN; i++) begin
      if (tick && (sync2[i] != btn_level[i]) && (cnt[i] == 4'(DEB_TICKS - 1)))
        lvl_next[i] = ~btn_level[i];
    end
  end

  assign rise = lvl_next & ~btn_level;

  // A bit leaving pend for the slot on this edge may be re-set by a new request without loss.
  always_comb begin
    slot_free = ~evt.press_valid | evt.press_ready;
    load      = slot_free & (|pend);
    load_idx  = lowest(pend);
    pend_clr  = '0;
    if (load) pend_clr[load_idx] = 1'b1;
    set_req   = rise | rep_set;
    drop      = set_req & pend & ~pend_clr;
    pend_next = (pend & ~pend_clr) | set_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1           <= '0;
      sync2           <= '0;
      btn_level       <= '0;
      pend            <= '0;
      press_lost      <= 1'b0;
      evt.press_valid <= 1'b0;
      evt.press_idx   <= '0;
      for (int unsigned i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      sync1      <= btn_raw;
      sync2      <= sync1;
      btn_level  <= lvl_next;
      pend       <= pend_next;
      press_lost <= press_lost | (|drop);
      if (tick) begin
        for (int unsigned i = 0; i < NBTN; i++) begin
          if ((sync2[i] == btn_level[i]) || (cnt[i] == 4'(DEB_TICKS - 1)))
            cnt[i] <= '0;
          else
            cnt[i] <= cnt[i] + 4'd1;
        end
      end
      if (slot_free) begin
        evt.press_valid <= load;
        if (load) evt.press_idx <= load_idx;
      end
    end
  end

`ifdef BTN_REPEAT_EN
  typedef enum logic [1:0] {TRK_IDLE, TRK_DELAY, TRK_RATE} trk_state_t;

  trk_state_t    trk_state;
  logic [IW-1:0] trk_idx, cur_idx;
  logic [7:0]    trk_cnt, trk_limit;
  logic          rep_fire;

  // The tracker only fires while it is still following the current lowest held button.
  always_comb begin
    cur_idx   = lowest(btn_level);
    trk_limit = (trk_state == TRK_RATE) ? 8'(REPEAT_RATE - 1) : 8'(REPEAT_DELAY - 1);
    rep_fire  = tick && any_held && (trk_state != TRK_IDLE) &&
                (cur_idx == trk_idx) && (trk_cnt == trk_limit);
    rep_set   = '0;
    if (rep_fire) rep_set[trk_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_state <= TRK_IDLE;
      trk_idx   <= '0;
      trk_cnt   <= '0;
    end else if (!any_held) begin
      trk_state <= TRK_IDLE;
      trk_cnt   <= '0;
    end else if ((trk_state == TRK_IDLE) || (cur_idx != trk_idx)) begin
      trk_state <= TRK_DELAY;
      trk_idx   <= cur_idx;
      trk_cnt   <= '0;
    end else if (rep_fire) begin
      trk_state <= TRK_RATE;
      trk_cnt   <= '0;
    end else if (tick) begin
      trk_cnt   <= trk_cnt + 8'd1;
    end
  end
`else
  always_comb rep_set = '0;
`endif
endmodule

// File: doc/button_event_unit.md
# button_event_unit

Front-end stage that turns the raw, bouncing push-button inputs into clean debounced levels and single press events. It sits directly upstream of the dice counter/display logic. It samples on the shared 32 Hz prescaler tick and queues presses so that none are lost while the consumer is busy. Each queued press is delivered through a valid/ready handshake as a button index.

## Interface
- NBTN, 7: number of buttons (2..8).
- DEB_TICKS, 4: consecutive differing tick samples required to change a debounced level (1..15).
- REPEAT_DELAY, 16: ticks a button must be held before the first auto-repeat (BTN_REPEAT_EN only, 1..255).
- REPEAT_RATE, 4: ticks between subsequent auto-repeats (BTN_REPEAT_EN only, 1..255).

- clk  in  1  system clock (32768 Hz).
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle sample strobe from the prescaler.
- btn_raw  in  NBTN  raw button inputs, active high, asynchronous.
- btn_level  out  NBTN  debounced levels.
- any_held  out  1  OR of btn_level.
- press_valid  out  1  a press event is presented.
- press_idx  out  IW = $clog2(NBTN)  index of the presented button; unsigned.
- press_ready  in  1  consumer accepts the event on an edge where press_valid=1.
- press_lost  out  1  sticky flag: a press was dropped because its pending bit was already set.

## Operation
- **Synchronizer:**
  - Each btn_raw bit passes through two flops on clk.
  - sync[i] is the second flop.
- **Debounce, per button, 4-bit counter cnt[i]:**
  - On a tick edge where sync[i] == btn_level[i], cnt[i] is cleared to 0.
  - On a tick edge where sync[i] != btn_level[i] and cnt[i] == DEB_TICKS-1, btn_level[i] toggles and cnt[i] is cleared to 0.
  - On any other tick edge where they differ, cnt[i] increments.
  - On non-tick edges, nothing changes.
- **Rise detect:** rise[i] is true on the edge where btn_level[i] goes 0→1. Falling levels generate no event.
- **Pending mask pend[NBTN]:**
  - rise[i] sets pend[i].
  - If pend[i] is already 1 and is not being cleared on the same edge, the rise is dropped and press_lost is set.
- **Output slot (press_valid, press_idx):**
  - The slot is free when press_valid=0, or when press_valid & press_ready is true at this edge.
  - When the slot is free and pend ≠ 0, the lowest set index is loaded into press_idx, press_valid is set to 1, and that pend bit is cleared, all on the same edge.
  - When the slot is free and pend == 0, press_valid goes to 0.
  - While press_valid=1 and press_ready=0, press_valid and press_idx hold stable.
- **Simultaneous events:**
  - A rise on a bit that is being loaded into the slot on the same edge re-sets that pend bit; it is not lost.
  - Multiple rises on the same edge are all recorded in pend and are delivered in ascending index order.
- **Reset values (rst high):** all flops are 0. That means btn_level=0, any_held=0, press_valid=0, press_idx=0, press_lost=0, pend=0, cnt=0, and synchronizers=0.
- **Reset mid-operation:** any queued or presented events are discarded. After reset is released, a button that is still held is re-debounced from level 0 and produces a fresh press.

## Timing
- Raw edge to sync: 2 clk.
- Sync change to btn_level change: DEB_TICKS tick edges. The first counted tick is the first tick edge after sync changes.
- btn_level rise and pend set happen on the same edge.
- pend set to press_valid=1: 1 clk when the slot is free.
- Back-to-back delivery: with press_ready held high, one event is presented per clk.
- any_held is combinational from btn_level.
- tick asserted on consecutive cycles is legal; each asserted cycle counts as one sample.

## Configuration
- **BTN_REPEAT_EN defined:**
  - A repeat tracker follows the lowest-indexed button with btn_level=1, using an 8-bit counter that counts tick edges.
  - The counter restarts when that button changes or all buttons are released.
  - After REPEAT_DELAY ticks held, it sets pend for that button (same drop rule as a rise, including press_lost). It then sets pend again every REPEAT_RATE ticks while the button is held.
- **BTN_REPEAT_EN undefined:** no tracker logic is built, REPEAT_* parameters are ignored, and exactly one event is produced per debounced press.

## Test plan
- **Clean press:**
  - Stimulus: DEB_TICKS=4, tick every 8 clk, btn_raw[2] rises and is held, press_ready=1.
  - Required: btn_level[2]=1 at the 4th tick edge after sync; press_valid high exactly 1 clk with press_idx=2; any_held=1.
- **Bounce rejection:**
  - Stimulus: btn_raw[0] toggles 1,0,1 across 3 successive ticks, then stays 0.
  - Required: btn_level stays 0 and no press_valid.
- **Simultaneous presses and backpressure:**
  - Stimulus: buttons 5, 1 and 3 rise on the same tick edge, press_ready=0 for 10 clk, then 1.
  - Required: press_idx=1 held for the 10 clk, then 3 and 5 on the next consecutive clk; press_lost=0.
- **Overflow:**
  - Stimulus: with press_ready=0, press button 4, release it, then press it twice more, each fully debounced.
  - Required: exactly one queued index-4 event remains pending behind the presented one; press_lost=1 until rst.
- **Reset mid-operation:**
  - Stimulus: assert rst for 1 clk while press_valid=1 and pend≠0, with button 6 still held.
  - Required: all outputs 0 immediately; a single press_idx=6 event appears DEB_TICKS ticks after release of rst.
- **BTN_REPEAT_EN:**
  - Stimulus: REPEAT_DELAY=16, REPEAT_RATE=4, hold button 0 for 30 ticks after debounce, press_ready=1.
  - Required: events at debounce, +16, +20, +24 and +28 ticks; with the macro undefined, only the first.
